// File: rtl/jtag_types_pkg.sv
// Shared types for the JTAG write-side packer: FSM state encoding.
package jtag_types_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } wr_state_e;

endpackage

// File: rtl/wr_hold_buf.sv
// Two-entry FIFO holding packed words until the write-pointer stage takes them.
module wr_hold_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]            count_q, count_d;
  logic [1:0]            slot;
  logic                  pop_ok, push_ok;

  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    // A push into a full buffer only lands when the head leaves on the same edge.
    push_ok = push && ((count_q != 2'd2) || pop_ok);
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (pop_ok) begin
      e0_d = e1_q;
      e1_d = '0;
    end
    slot = count_q - {1'b0, pop_ok};
    if (push_ok) begin
      if (slot == 2'd0) e0_d = push_data;
      else              e1_d = push_data;
    end
    count_d = slot + {1'b0, push_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = (count_q != 2'd0) ? e0_q : '0;

endmodule

// File: rtl/jtag_wr_packer.sv
// Packs LSB-first TDI bits from DR scans into words and hands them to the
// async-FIFO write-pointer stage through a two-entry holding buffer.
module jtag_wr_packer
  import jtag_types_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wclk,
  input  logic                  w_rst,
  input  logic                  capture,
  input  logic                  shift,
  input  logic                  tdi,
  input  logic                  update,
  input  logic                  full,
  input  logic                  clr_ovf,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [1:0]            dbg_state
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  wr_state_e             state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_shifted, padded;
  logic                  ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic                  do_shift, do_flush, word_done, push, drop;
  logic [DATA_WIDTH-1:0] push_data, head;
  logic [1:0]            count;

  // State register
  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; update looks at the bit count after this cycle's shift.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (capture || shift) state_d = ST_SHIFT;
      ST_SHIFT: if (!capture && update)
                  state_d = (bit_cnt_d != '0) ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: state_d = capture ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: capture overrides both shifting and a pending flush.
  always_comb begin
    do_shift = 1'b0;
    do_flush = 1'b0;
    case (state_q)
      ST_IDLE, ST_SHIFT: do_shift = shift && !capture;
      ST_FLUSH:          do_flush = !capture;
      default:           ;
    endcase
  end

  always_comb begin
    sr_shifted            = sr_q;
    sr_shifted[bit_cnt_q] = tdi;
    for (int i = 0; i < DATA_WIDTH; i++)
      padded[i] = (i < int'({1'b0, bit_cnt_q})) ? sr_q[i] : 1'b0;
    word_done = do_shift && (bit_cnt_q == LAST);
    push      = word_done || do_flush;
    push_data = word_done ? sr_shifted : padded;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    if (capture || do_flush || word_done) begin
      bit_cnt_d = '0;
      sr_d      = '0;
    end else if (do_shift) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      sr_d      = sr_shifted;
    end
  end

  // Handshake: a word transfers on every rising edge where winc=1; winc is
  // valid (buffer non-empty) gated by the write stage's full, and wdata is
  // stable while winc is high.
  assign winc = (count != 2'd0) && !full;
  assign drop = push && (count == 2'd2) && !winc;

  always_comb begin
    ovf_d      = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, winc};
  end

  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) begin
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      ovf_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      ovf_q      <= ovf_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  wr_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
    .clk       (wclk),
    .rst       (w_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (winc),
    .count     (count),
    .head      (head)
  );

  assign wdata     = head;
  assign busy      = (state_q != ST_IDLE) || (count != 2'd0);
  assign overflow  = ovf_q;
  assign word_cnt  = word_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_jtag_wr_packer.sv
// Directed bench for jtag_wr_packer with a queue-level behavioural model.
module tb_jtag_wr_packer;

  localparam int W  = 32;
  localparam int CW = 16;

  logic          wclk = 1'b0;
  logic          w_rst, capture, shift, tdi, update, full, clr_ovf;
  logic          winc, busy, overflow;
  logic [W-1:0]  wdata;
  logic [CW-1:0] word_cnt;
  logic [1:0]    dbg_state;

  always #5 wclk = ~wclk;

  jtag_wr_packer #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .wclk      (wclk),
    .w_rst     (w_rst),
    .capture   (capture),
    .shift     (shift),
    .tdi       (tdi),
    .update    (update),
    .full      (full),
    .clr_ovf   (clr_ovf),
    .winc      (winc),
    .wdata     (wdata),
    .busy      (busy),
    .overflow  (overflow),
    .word_cnt  (word_cnt),
    .dbg_state (dbg_state)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Hand-computed words in the order they must leave the packer.
  logic [W-1:0] exp_q[$];

  // Model: scan bits collected so far, buffered words, flags.
  logic          m_bits[$];
  logic [W-1:0]  m_hold[$];
  bit            m_scan, m_flush, m_ovf;
  logic [CW-1:0] m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w = '0;
    for (int i = 0; i < m_bits.size(); i++) w[i] = m_bits[i];
    return w;
  endfunction

  task automatic model_step();
    logic [W-1:0] word, gone;
    bit have, was_scan, dropped;
    if (w_rst) begin
      m_bits.delete(); m_hold.delete();
      m_scan = 0; m_flush = 0; m_ovf = 0; m_cnt = '0;
      return;
    end
    have = 0;
    word = '0;
    if (m_hold.size() > 0 && !full) begin
      gone = m_hold.pop_front();
      m_cnt++;
    end
    was_scan = m_scan;
    if (capture) begin
      m_bits.delete(); m_scan = 1; m_flush = 0;
    end else if (m_flush) begin
      word = pack_bits(); have = 1; m_bits.delete(); m_flush = 0;
    end else begin
      if (shift) begin
        m_bits.push_back(tdi);
        m_scan = 1;
        if (m_bits.size() == W) begin
          word = pack_bits(); have = 1; m_bits.delete();
        end
      end
      if (update && was_scan) begin
        m_scan  = 0;
        m_flush = (m_bits.size() != 0);
      end
    end
    dropped = 0;
    if (have) begin
      if (m_hold.size() < 2) m_hold.push_back(word);
      else begin m_ovf = 1; dropped = 1; end
    end
    if (clr_ovf && !dropped) m_ovf = 0;
  endtask

  initial forever begin
    @(posedge wclk or posedge w_rst);
    model_step();
  end

  // Compare process: every falling edge.
  initial forever begin
    @(negedge wclk);
    check("winc", winc, (m_hold.size() != 0) && !full);
    check("wdata", wdata, (m_hold.size() != 0) ? m_hold[0] : '0);
    check("busy", busy, m_scan || m_flush || (m_hold.size() != 0));
    check("overflow", overflow, m_ovf);
    check("word_cnt", word_cnt, m_cnt);
    if (winc) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_extra actual=%0h required=none at %0t", wdata, $time);
      end else begin
        check("sb_order", wdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge wclk);
    #2;
  endtask

  task automatic do_capture();
    capture = 1'b1; tick(); capture = 1'b0;
  endtask

  task automatic do_update();
    update = 1'b1; tick(); update = 1'b0;
  endtask

  task automatic shift_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      shift = 1'b1; tdi = w[i]; tick();
    end
    shift = 1'b0; tdi = 1'b0;
  endtask

  initial begin
    w_rst = 1'b1; capture = 0; shift = 0; tdi = 0; update = 0; full = 0; clr_ovf = 0;
    repeat (2) tick();
    check("rst_winc", winc, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_word_cnt", word_cnt, 0);
    w_rst = 1'b0;
    tick();

    // Full word straight through.
    exp_q.push_back(32'hA5A5_0F0F);
    do_capture();
    shift_bits(32'hA5A5_0F0F, 32);
    check("t36_winc", winc, 1);
    check("t36_wdata", wdata, 32'hA5A5_0F0F);
    tick();
    check("t36_cnt", word_cnt, 1);
    do_update();

    // Partial byte flushed on update.
    exp_q.push_back(32'h0000_003C);
    do_capture();
    shift_bits(32'h3C, 8);
    do_update();
    check("t37_flush_state", dbg_state, 2);
    tick();
    check("t37_winc", winc, 1);
    check("t37_wdata", wdata, 32'h0000_003C);
    check("t37_idle_state", dbg_state, 0);
    tick();
    check("t37_cnt", word_cnt, 2);

    // Third word dropped while the write stage is full.
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h9ABC_DEF0);
    full = 1'b1;
    do_capture();
    shift_bits(32'h1234_5678, 32);
    shift_bits(32'h9ABC_DEF0, 32);
    shift_bits(32'h0BAD_F00D, 32);
    check("t38_ovf_set", overflow, 1);
    check("t38_winc_held", winc, 0);
    do_update();
    full = 1'b0;
    repeat (3) tick();
    check("t38_cnt", word_cnt, 4);
    check("t38_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t38_ovf_clr", overflow, 0);

    // Buffer full, pop and push land on the same edge.
    exp_q.push_back(32'hCAFE_BABE);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h00C0_FFEE);
    full = 1'b1;
    do_capture();
    shift_bits(32'hCAFE_BABE, 32);
    shift_bits(32'hDEAD_BEEF, 32);
    shift_bits(32'h00C0_FFEE, 31);
    full = 1'b0; shift = 1'b1; tdi = 1'b0; tick(); shift = 1'b0;
    check("t39_no_ovf", overflow, 0);
    do_update();
    repeat (3) tick();
    check("t39_cnt", word_cnt, 7);

    // Reset mid-scan with a buffered word.
    full = 1'b1;
    do_capture();
    shift_bits(32'h55AA_55AA, 32);
    shift_bits(32'h000F_FFFF, 20);
    check("t40_busy_pre", busy, 1);
    w_rst = 1'b1;
    #1;
    check("t40_rst_winc", winc, 0);
    check("t40_rst_busy", busy, 0);
    check("t40_rst_cnt", word_cnt, 0);
    tick();
    w_rst = 1'b0; full = 1'b0;
    tick();
    exp_q.push_back(32'h0000_0001);
    do_capture();
    shift_bits(32'h0000_0001, 32);
    check("t40_wdata", wdata, 32'h0000_0001);
    tick();
    check("t40_cnt", word_cnt, 1);
    do_update();

    // Capture discards a partial scan.
    exp_q.push_back(32'hFFFF_FFFF);
    do_capture();
    shift_bits(W'($urandom_range(0, 1023)), 10);
    do_capture();
    shift_bits(32'hFFFF_FFFF, 32);
    do_update();
    repeat (2) tick();
    check("t41_cnt", word_cnt, 2);

    // Shift and update together on a partial word.
    exp_q.push_back(32'h0000_000A);
    do_capture();
    shift_bits(32'h0000_000A, 3);
    shift = 1'b1; tdi = 1'b1; update = 1'b1; tick();
    shift = 1'b0; update = 1'b0;
    check("t42_flush_state", dbg_state, 2);
    tick();
    check("t42_wdata", wdata, 32'h0000_000A);
    tick();
    check("t42_cnt", word_cnt, 3);

    // Shift and update together on the last bit of a word.
    exp_q.push_back(32'h8765_4321);
    do_capture();
    shift_bits(32'h8765_4321, 31);
    shift = 1'b1; tdi = 1'b1; update = 1'b1; tick();
    shift = 1'b0; update = 1'b0;
    check("t43_idle_state", dbg_state, 0);
    check("t43_wdata", wdata, 32'h8765_4321);
    tick();
    check("t43_cnt", word_cnt, 4);

    // Capture keeps already buffered words.
    exp_q.push_back(32'h0F0F_0F0F);
    full = 1'b1;
    do_capture();
    shift_bits(32'h0F0F_0F0F, 32);
    shift_bits(32'h1F, 5);
    do_capture();
    do_update();
    full = 1'b0;
    repeat (3) tick();
    check("t44_cnt", word_cnt, 5);
    check("t44_idle", busy, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
